lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I core.
- Consumes the EX/MEM register outputs (address, store data, write enable, load flag, width select) and drives a valid/grant data-bus.
- Formats byte lanes and returns sign- or zero-extended load data toward MEM/WB.
- Holds the pipeline with stall_o while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: bus-wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-low reset.
- rden_i, input, 1: load in MEM stage.
- wren_i, input, 1: store in MEM stage.
- rwsel_i, input, 3: funct3 width select. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i, input, 32: effective address (ALU result).
- sdata_i, input, 32: store data (rs2).
- ldata_o, output, 32: extended load result; valid while done_o=1.
- done_o, output, 1: one-cycle pulse, access complete.
- stall_o, output, 1: freeze IF..EX/MEM while high.
- err_o, output, 1: one-cycle pulse; misaligned access, illegal rwsel, or timeout.
- bus_req_o, output, 1: request valid.
- bus_we_o, output, 1: 1 = write.
- bus_addr_o, output, 32: word address, bits [1:0] forced to 00.
- bus_be_o, output, 4: byte enables.
- bus_wdata_o, output, 32: lane-replicated write data.
- bus_gnt_i, input, 1: request accepted this cycle.
- bus_rvalid_i, input, 1: read data valid.
- bus_rdata_i, input, 32: read data word.

Behaviour:
- Reset: the clock is clk; reset is rst, asynchronous, active-low. All outputs are 0; state is IDLE; captured address, data and width registers are 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, start = (rden_i | wren_i):
  - Legal and aligned: capture addr, sdata, rwsel and we (wren_i wins if both are set) and go to REQ. stall_o=1 combinationally in this cycle.
  - Misaligned (H/HU/SH with addr[0]=1; W with addr[1:0]≠0) or rwsel_i ∈ {011, 110, 111}: no bus activity, err_o pulses for 1 cycle, stall_o=0, remain in IDLE.
- REQ:
  - bus_req_o=1, with addr/we/be/wdata held stable from registers until bus_gnt_i.
  - On gnt: a store goes to DONE; a load goes to WAIT. bus_req_o drops the cycle after gnt.
  - stall_o=1.
- WAIT:
  - stall_o=1. bus_rvalid_i may arrive at the earliest one cycle after gnt.
  - On rvalid: capture bus_rdata_i, then go to DONE.
- DONE:
  - done_o=1, stall_o=0, ldata_o valid (0 for stores).
  - Go to IDLE unconditionally. The pipeline advances at the end of this cycle, so start is ignored in DONE.
- Byte lanes, o = addr[1:0]:
  - SB: be = 0001 << o, wdata = {4{sdata[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011, wdata = {2{sdata[15:0]}}.
  - SW: be = 1111, wdata = sdata.
  - Loads: be per width, same as stores.
- Load extend: select byte/half = rdata >> (8*o). B/H sign-extend; BU/HU zero-extend; W passes through.
- Minimum latencies, counted IDLE-accept to done_o: store with gnt in the first REQ cycle = 2 cycles; load with rvalid 1 cycle after gnt = 3 cycles.
- bus_rvalid_i outside WAIT is ignored. bus_gnt_i outside REQ is ignored.
- Reset mid-transaction drops bus_req_o immediately; a late rvalid after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter, width $clog2(TIMEOUT_CYCLES+1), clears on entry to REQ and increments in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES, go to DONE with err_o=1, ldata_o=0 and bus_req_o dropped.
- Undefined: no counter; REQ/WAIT wait indefinitely.

Decomposition:
- Package lsu_pkg:
  - funct3 width constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum: IDLE, REQ, WAIT, DONE.
- Sub-module lsu_align (combinational): generates be/wdata from (rwsel, offset, sdata) and load extend from (rwsel, offset, rdata).
- The FSM and registers live in lsu.

Test Plan:
1. SW: addr=0x100, sdata=0xDEADBEEF, gnt in the first REQ cycle → bus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1. done_o in cycle 2, stall_o high for exactly 2 cycles (IDLE-accept, REQ), low in DONE.
2. SB: addr=0x203, sdata=0x000000A5 → be=1000, wdata=0xA5A5A5A5, bus_addr=0x200.
3. LB: addr=0x301, rdata=0x0000F000, rvalid 1 cycle after gnt → ldata_o=0xFFFFFFF0. Same access with LBU → ldata_o=0x000000F0.
4. LH addr=0x401 → err_o 1-cycle pulse, bus_req_o never asserted, stall_o=0. Repeat with LW addr=0x402, then with rwsel=011 → same response.
5. gnt delayed 3 cycles → bus_addr/be/wdata stable throughout REQ. Then assert rst low while in WAIT → all outputs 0 asynchronously; a subsequent rvalid produces no done_o.
6. (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) load with gnt but no rvalid → err_o and done_o assert together, ldata_o=0, back to IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Width codes, FSM state type and access-legality helper shared by the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    // An access is legal when the width code exists and the address is naturally aligned.
    function automatic logic lsu_legal(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~lo[0];
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and sign/zero extension for loads; purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_rwsel,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shift;

    assign w_shift = i_rdata >> {i_offset, 3'b000};

    // Bits [1:0] of the width code give the access size for both signed and unsigned loads.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_sdata;
        case (i_rwsel[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_sdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_sdata[15:0]}};
            end
            2'b10: begin
                o_be    = 4'b1111;
                o_wdata = i_sdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_sdata;
            end
        endcase
    end

    always_comb begin
        o_ldata = 32'h0;
        case (i_rwsel)
            F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_W:    o_ldata = i_rdata;
            F3_BU:   o_ldata = {24'h0, w_shift[7:0]};
            F3_HU:   o_ldata = {16'h0, w_shift[15:0]};
            default: o_ldata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit driving a valid/grant data bus; define LSU_TIMEOUT_EN for a bus-wait watchdog.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [2:0]  rwsel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] ldata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    // Bus handshake: a request stays up with stable fields until the cycle bus_gnt_i is high;
    // read data is taken only in WAIT on bus_rvalid_i, which may not arrive before the cycle after grant.
    lsu_state_t  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [31:0] r_ldata;
    logic [2:0]  r_rwsel;
    logic        r_we;
    logic        r_to_err;

    logic        w_start;
    logic        w_accept;
    logic        w_bad;
    logic        w_in_req;
    logic        w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    assign w_start  = rst & (rden_i | wren_i);
    assign w_accept = (r_state == IDLE) & w_start & lsu_legal(rwsel_i, addr_i[1:0]);
    assign w_bad    = (r_state == IDLE) & w_start & ~lsu_legal(rwsel_i, addr_i[1:0]);
    assign w_in_req = (r_state == REQ);
    assign w_done   = (r_state == DONE);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    lsu_align u_align (
        .i_rwsel  (r_rwsel),
        .i_offset (r_addr[1:0]),
        .i_sdata  (r_sdata),
        .i_rdata  (bus_rdata_i),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_ldata  (w_ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_addr   <= 32'h0;
            r_sdata  <= 32'h0;
            r_ldata  <= 32'h0;
            r_rwsel  <= 3'b000;
            r_we     <= 1'b0;
            r_to_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= addr_i;
                        r_sdata  <= sdata_i;
                        r_rwsel  <= rwsel_i;
                        r_we     <= wren_i;
                        r_ldata  <= 32'h0;
                        r_to_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                        r_state  <= REQ;
                    end
                end
                REQ: begin
`ifdef LSU_TIMEOUT_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    if (bus_gnt_i) begin
                        r_state <= r_we ? DONE : WAIT;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_expire) begin
                        r_to_err <= 1'b1;
                        r_state  <= DONE;
                    end
`endif
                end
                WAIT: begin
`ifdef LSU_TIMEOUT_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    if (bus_rvalid_i) begin
                        r_ldata <= w_ldata;
                        r_state <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_expire) begin
                        r_to_err <= 1'b1;
                        r_state  <= DONE;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle combinationally so the instruction is held before REQ registers.
    assign stall_o     = w_accept | w_in_req | (r_state == WAIT);
    assign done_o      = w_done;
    assign err_o       = w_bad | (w_done & r_to_err);
    assign ldata_o     = w_done ? r_ldata : 32'h0;

    assign bus_req_o   = w_in_req;
    assign bus_we_o    = w_in_req & r_we;
    assign bus_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus_be_o    = w_in_req ? w_be : 4'b0000;
    assign bus_wdata_o = w_in_req ? w_wdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu; the timeout case is included when LSU_TIMEOUT_EN is defined.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        rden_i;
    logic        wren_i;
    logic [2:0]  rwsel_i;
    logic [31:0] addr_i;
    logic [31:0] sdata_i;
    logic [31:0] ldata_o;
    logic        done_o;
    logic        stall_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rden_i       (rden_i),
        .wren_i       (wren_i),
        .rwsel_i      (rwsel_i),
        .addr_i       (addr_i),
        .sdata_i      (sdata_i),
        .ldata_o      (ldata_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues: bus fields {we, addr, be, wdata} and responses {done, err, ldata}
    logic [68:0] bus_q[$];
    logic [33:0] exp_q[$];

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus_req_o) begin
                if (bus_q.size() == 0) chk("bus_unexpected", 69'(bus_req_o), 69'd0);
                else begin
                    chk("bus_fields", {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}, bus_q[0]);
                    if (bus_gnt_i) void'(bus_q.pop_front());
                end
            end
            if (done_o || err_o) begin
                if (exp_q.size() == 0) chk("resp_unexpected", 69'({done_o, err_o}), 69'd0);
                else chk("resp", 69'({done_o, err_o, ldata_o}), 69'(exp_q.pop_front()));
            end
        end
    end

    // Driver: starts at posedge+1 with the DUT idle
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int gdly, input int rdly, input logic [31:0] rdata,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                          input logic legal, input int elat);
        int cyc;
        rden_i  = rd;
        wren_i  = wr;
        rwsel_i = f3;
        addr_i  = a;
        sdata_i = sd;
        if (legal) begin
            bus_q.push_back({wr, a & ~32'h3, ebe, ewd});
            exp_q.push_back({2'b10, eld});
        end else begin
            exp_q.push_back({2'b01, 32'h0});
        end
        @(negedge clk);
        chk("stall_accept", 69'(stall_o), 69'(legal));
        @(posedge clk); #1;
        rden_i  = 1'b0;
        wren_i  = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("illegal_no_req", 69'({bus_req_o, stall_o, err_o}), 69'd0);
            @(posedge clk); #1;
            return;
        end
        cyc = 1;
        for (int i = 0; i < gdly; i++) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        cyc++;
        if (!wr) begin
            for (int i = 0; i < rdly; i++) begin
                @(posedge clk); #1;
                cyc++;
            end
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdata;
            @(posedge clk); #1;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = 32'h0;
            cyc++;
        end
        @(negedge clk);
        chk("done_latency", 69'({done_o, stall_o, cyc}), 69'({1'b1, 1'b0, elat}));
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        rden_i = 1'b0; wren_i = 1'b0; rwsel_i = 3'b000; addr_i = 32'h0; sdata_i = 32'h0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_bus", {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}, 69'd0);
        chk("reset_ctl", 69'({bus_req_o, done_o, err_o, stall_o, ldata_o}), 69'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stores
        access(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, 1, 2);
        access(0, 1, F3_B, 32'h203, 32'h000000A5, 0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0, 1, 2);
        access(0, 1, F3_H, 32'h702, 32'h1234BEEF, 0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, 1, 2);
        access(1, 1, F3_W, 32'h900, 32'h55667788, 0, 0, 32'h0, 4'b1111, 32'h55667788, 32'h0, 1, 2);
        // Loads
        access(1, 0, F3_B,  32'h301, 32'h0, 0, 0, 32'h0000F000, 4'b0010, 32'h0, 32'hFFFFFFF0, 1, 3);
        access(1, 0, F3_BU, 32'h301, 32'h0, 0, 0, 32'h0000F000, 4'b0010, 32'h0, 32'h000000F0, 1, 3);
        access(1, 0, F3_H,  32'h402, 32'h0, 0, 0, 32'h80010000, 4'b1100, 32'h0, 32'hFFFF8001, 1, 3);
        access(1, 0, F3_HU, 32'h506, 32'h0, 0, 1, 32'h12345678, 4'b1100, 32'h0, 32'h00001234, 1, 4);
        access(1, 0, F3_W,  32'h600, 32'h0, 0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 1, 3);
        access(1, 0, F3_BU, 32'hA02, 32'h0, 0, 2, 32'h00AB0000, 4'b0100, 32'h0, 32'h000000AB, 1, 5);
        // Misaligned and illegal width codes
        access(1, 0, F3_H,   32'h401, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0);
        access(1, 0, F3_W,   32'h402, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0);
        access(1, 0, 3'b011, 32'h400, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0);
        access(0, 1, F3_W,   32'h101, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0);
        // Delayed grant
        access(1, 0, F3_W, 32'h800, 32'h0, 3, 0, 32'h11223344, 4'b1111, 32'h0, 32'h11223344, 1, 6);
        access(0, 1, F3_B, 32'hB01, 32'h0000007E, 2, 0, 32'h0, 4'b0010, 32'h7E7E7E7E, 32'h0, 1, 4);

        // Stray grant and read-valid while idle
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        @(negedge clk);
        chk("stray_ignored", 69'({bus_req_o, done_o, stall_o}), 69'd0);
        @(posedge clk); #1;

        // Reset while waiting for read data
        rden_i = 1'b1; rwsel_i = F3_W; addr_i = 32'hC00; sdata_i = 32'h0;
        bus_q.push_back({1'b0, 32'hC00, 4'b1111, 32'h0});
        @(posedge clk); #1;
        rden_i = 1'b0;
        bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_bus", {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}, 69'd0);
        chk("abort_ctl", 69'({bus_req_o, done_o, err_o, stall_o, ldata_o}), 69'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid_ignored", 69'({done_o, stall_o}), 69'd0);
        end
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        rden_i = 1'b1; rwsel_i = F3_W; addr_i = 32'hD00;
        bus_q.push_back({1'b0, 32'hD00, 4'b1111, 32'h0});
        exp_q.push_back({2'b11, 32'h0});
        @(posedge clk); #1;
        rden_i = 1'b0;
        bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("timeout_done", 69'(seen), 69'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_idle", 69'({bus_req_o, stall_o, done_o}), 69'd0);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        chk("bus_q_drained", 69'(bus_q.size()), 69'd0);
        chk("exp_q_drained", 69'(exp_q.size()), 69'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
